// File: rtl/serial_slave.sv
// Serial-bus storage slave: shifts in an address (and write data), waits a
// fixed number of cycles, then stores or streams back one data word.
module serial_slave #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int WAIT_CYC = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic mode,
    input  logic wr_bus,
    input  logic master_valid,
    input  logic master_ready,
    output logic rd_bus,
    output logic slave_ready,
    output logic slave_valid
);

    typedef enum logic [2:0] {
        IDLE, ADDR, WDATA, WWAIT, RWAIT, RDATA
    } state_t;

    localparam int MAXB = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int BW   = $clog2(MAXB + 1);
    localparam int WW   = $clog2(WAIT_CYC + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] A_LAST = BW'(ADDR_W - 1);
    localparam logic [BW-1:0] D_LAST = BW'(DATA_W - 1);
    localparam logic [WW-1:0] W_LAST = WW'(WAIT_CYC - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-2:0]   data_q, data_d;
    logic [DATA_W-1:0]   rsh_q, rsh_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [WW-1:0]       wait_q, wait_d;
    logic [TW-1:0]       to_q, to_d;

    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [DATA_W-1:0]   wdata;
    logic                mem_we;
    logic                in_hs;
    logic                out_hs;

    always_comb begin
        slave_ready = (state_q == IDLE) || (state_q == ADDR) ||
                      (state_q == WDATA);
        slave_valid = (state_q == RDATA);
        rd_bus      = (state_q == RDATA) ? rsh_q[DATA_W-1] : 1'b0;
    end

    assign in_hs  = master_valid && slave_ready;
    assign out_hs = slave_valid && master_ready;
    // Final word is the held bits plus the bit on the bus this edge.
    assign wdata  = {data_q, wr_bus};

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rsh_d   = rsh_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        to_d    = '0;
        mem_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    mode_d  = mode;
                    addr_d  = ADDR_W'(wr_bus);
                    bit_d   = BW'(1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (in_hs) begin
                    addr_d = {addr_q[ADDR_W-2:0], wr_bus};
                    if (bit_q == A_LAST) begin
                        bit_d   = '0;
                        state_d = mode_q ? WDATA : RWAIT;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            WDATA: begin
                if (in_hs) begin
                    data_d = wdata[DATA_W-2:0];
                    if (bit_q == D_LAST) begin
                        mem_we  = 1'b1;
                        bit_d   = '0;
                        state_d = WWAIT;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            WWAIT: begin
                if (wait_q == W_LAST) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RWAIT: begin
                if (wait_q == W_LAST) begin
                    rsh_d   = mem[addr_q];
                    wait_d  = '0;
                    state_d = RDATA;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RDATA: begin
                if (out_hs) begin
                    rsh_d = {rsh_q[DATA_W-2:0], 1'b0};
                    if (bit_q == D_LAST) begin
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Stall watchdog for the phases that need the master to move.
        if ((state_q == ADDR || state_q == WDATA || state_q == RDATA) &&
            !in_hs && !out_hs) begin
            to_d = to_q + 1'b1;
            if (to_d == T_MAX) begin
                state_d = IDLE;
            end
        end

        if (state_d == IDLE && state_q != IDLE) begin
            mode_d = 1'b0;
            addr_d = '0;
            data_d = '0;
            rsh_d  = '0;
            bit_d  = '0;
            wait_d = '0;
            to_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rsh_q   <= '0;
            bit_q   <= '0;
            wait_q  <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rsh_q   <= rsh_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata;
        end
    end

endmodule
